// File: rtl/psum_accumulator_if.sv
// Handshake bundle between the sparse scheduler, the psum accumulator and the writeback stream.
// The product-beat input stream and the drained-cell output stream travel together.
interface psum_accumulator_if #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned LANES     = 4,
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4
);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);

    logic                       in_valid;
    logic                       in_ready;
    logic [LANES-1:0]           lane_valid;
    logic [LANES*WORD_SIZE-1:0] prod_data;
    logic [LANES*ROW_W-1:0]     prod_row;
    logic [LANES*COL_W-1:0]     prod_col;
    logic                       in_last;

    logic                       out_valid;
    logic                       out_ready;
    logic [WORD_SIZE-1:0]       out_data;
    logic [ROW_W-1:0]           out_row;
    logic [COL_W-1:0]           out_col;
    logic                       out_last;

    // Producer / consumer side (scheduler plus writeback)
    modport master (
        output in_valid, lane_valid, prod_data, prod_row, prod_col, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last
    );

    // Accumulator side
    modport slave (
        input  in_valid, lane_valid, prod_data, prod_row, prod_col, in_last, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_last
    );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates per-lane partial products into a dense ROWS x COLS tile.
// The finished tile drains row-major and each cell is cleared as it leaves.
module psum_accumulator #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned LANES     = 4,
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    psum_accumulator_if.slave  bus
);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned IDX_W = ROW_W + COL_W;
    localparam int unsigned CELLS = ROWS * COLS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     k_q, k_d;
    logic [WORD_SIZE-1:0] cell_q [CELLS];
    logic [WORD_SIZE-1:0] cell_d [CELLS];
    logic [IDX_W-1:0]     lane_idx [LANES];

    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [WORD_SIZE-1:0] out_data_q;
    logic [ROW_W-1:0]     out_row_q;
    logic [COL_W-1:0]     out_col_q;
    logic                 out_last_q;

    logic accept_c;
    logic out_hs_c;

    assign accept_c = (state_q == ACCUM) && bus.in_valid;
    assign out_hs_c = (state_q == DRAIN) && bus.out_ready;

    // Flat cell index of each lane; COLS is a power of two so {row,col} == row*COLS+col
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = {bus.prod_row[l*ROW_W +: ROW_W], bus.prod_col[l*COL_W +: COL_W]};
        end
    end

    // Next tile state: sum every matching lane into each cell, or clear the drained cell
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        for (int c = 0; c < CELLS; c++) begin
            cell_d[c] = cell_q[c];
            if (accept_c) begin
                for (int l = 0; l < LANES; l++) begin
                    if (bus.lane_valid[l] && (lane_idx[l] == IDX_W'(c))) begin
                        cell_d[c] = cell_d[c] + bus.prod_data[l*WORD_SIZE +: WORD_SIZE];
                    end
                end
            end
            if (out_hs_c && (k_q == IDX_W'(c))) begin
                cell_d[c] = '0;
            end
        end

        if (accept_c && bus.in_last) begin
            state_d = DRAIN;
        end

        if (out_hs_c) begin
            if (k_q == LAST_IDX) begin
                k_d     = '0;
                state_d = ACCUM;
            end else begin
                k_d = k_q + IDX_W'(1);
            end
        end
    end

    // State, tile and registered output stream; outputs are precomputed from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            k_q         <= '0;
            for (int c = 0; c < CELLS; c++) begin
                cell_q[c] <= '0;
            end
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            for (int c = 0; c < CELLS; c++) begin
                cell_q[c] <= cell_d[c];
            end
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == DRAIN);
            out_data_q  <= (state_d == DRAIN) ? cell_d[k_d] : '0;
            out_row_q   <= k_d[IDX_W-1:COL_W];
            out_col_q   <= k_d[COL_W-1:0];
            out_last_q  <= (state_d == DRAIN) && (k_d == LAST_IDX);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_last  = out_last_q;
endmodule
